// File: rtl/scan_seq4_if.sv
// rtl/scan_seq4_if.sv - control and select bundle between a scan controller and scan_seq4
interface scan_seq4_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               mode;
    logic [DWELL_W-1:0] dwell;
    logic [15:0]        skip_mask;
    logic [3:0]         sel;
    logic               sel_valid;
    logic               frame_done;
    logic               busy;

    modport master (
        output start, stop, mode, dwell, skip_mask,
        input  sel, sel_valid, frame_done, busy
    );

    modport slave (
        input  start, stop, mode, dwell, skip_mask,
        output sel, sel_valid, frame_done, busy
    );
endinterface

// File: rtl/scan_seq4.sv
// rtl/scan_seq4.sv - 4-bit scan sequencer driving the active-low 4-to-16 decoder address/enable
// Optional inter-index blanking is compiled in with SCAN_SEQ_BLANK_EN.
module scan_seq4 #(
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    scan_seq4_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;

`ifdef SCAN_SEQ_BLANK_EN
    localparam bit BLANK_ON = (BLANK_CYC != 0);
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    state_t             state, state_n;
    logic [3:0]         sel_q, sel_n;
    logic               valid_q, valid_n;
    logic               fd_q, fd_n;
    logic               busy_q, busy_n;
    logic               stop_lat, stop_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [3:0]         bcnt, bcnt_n;

    logic [3:0]         nxt_hi, nxt_lo, nxt;
    logic               found_hi, wrap, all_ones, stop_eff;
    logic [DWELL_W-1:0] dwell_load;

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        nxt_hi   = 4'd0;
        nxt_lo   = 4'd0;
        found_hi = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (!bus.skip_mask[i]) begin
                nxt_lo = 4'(i);
                if (i > int'(sel_q)) begin
                    nxt_hi   = 4'(i);
                    found_hi = 1'b1;
                end
            end
        end
    end

    assign wrap       = !found_hi;
    assign nxt        = found_hi ? nxt_hi : nxt_lo;
    assign all_ones   = &bus.skip_mask;
    assign stop_eff   = stop_lat | bus.stop;
    assign dwell_load = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_q    <= 4'd0;
            valid_q  <= 1'b0;
            fd_q     <= 1'b0;
            busy_q   <= 1'b0;
            stop_lat <= 1'b0;
            cnt      <= '0;
            bcnt     <= 4'd0;
        end else begin
            state    <= state_n;
            sel_q    <= sel_n;
            valid_q  <= valid_n;
            fd_q     <= fd_n;
            busy_q   <= busy_n;
            stop_lat <= stop_n;
            cnt      <= cnt_n;
            bcnt     <= bcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel_q;
        valid_n = valid_q;
        fd_n    = 1'b0;
        stop_n  = stop_lat | (busy_q & bus.stop);
        cnt_n   = cnt;
        bcnt_n  = bcnt;
        case (state)
            IDLE: begin
                valid_n = 1'b0;
                stop_n  = 1'b0;
                if (bus.start && !bus.stop && !all_ones) begin
                    state_n = DWELL;
                    sel_n   = nxt_lo;
                    valid_n = 1'b1;
                    cnt_n   = dwell_load;
                end
            end
            DWELL: begin
                if (cnt > DWELL_W'(1)) begin
                    cnt_n = cnt - DWELL_W'(1);
                end else begin
                    // Leaving the highest unmasked index closes the frame regardless of why we stop.
                    fd_n = wrap;
                    if (stop_eff || (bus.mode && wrap) || all_ones) begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                        stop_n  = 1'b0;
                    end else if (BLANK_ON) begin
                        state_n = BLANK;
                        valid_n = 1'b0;
                        bcnt_n  = 4'(BLANK_CYC);
                    end else begin
                        sel_n = nxt;
                        cnt_n = dwell_load;
                    end
                end
            end
            BLANK: begin
                if (bcnt > 4'd1) begin
                    bcnt_n = bcnt - 4'd1;
                end else if (stop_eff || all_ones) begin
                    state_n = IDLE;
                    stop_n  = 1'b0;
                    fd_n    = !stop_eff;
                end else begin
                    state_n = DWELL;
                    sel_n   = nxt;
                    valid_n = 1'b1;
                    cnt_n   = dwell_load;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    assign bus.sel        = sel_q;
    assign bus.sel_valid  = valid_q;
    assign bus.frame_done = fd_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_scan_seq4.sv
// tb/tb_scan_seq4.sv - randomized scoreboard bench for scan_seq4
module tb_scan_seq4;
    localparam int DW    = 8;
    localparam int BCYC  = 2;
`ifdef SCAN_SEQ_BLANK_EN
    localparam int BLK = BCYC;
`else
    localparam int BLK = 0;
`endif

    typedef struct packed {
        logic       v;
        logic [3:0] s;
        logic       fd;
        logic       b;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [3:0] cur_sel = 4'd0;
    bit   fd_p = 1'b0;

    scan_seq4_if #(.DWELL_W(DW)) bus ();
    scan_seq4 #(.DWELL_W(DW), .BLANK_CYC(BCYC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Monitor: one expected output tuple per clock while a run is in flight.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sel_valid", bus.sel_valid, e.v);
                if (e.v) chk("sel", bus.sel, e.s);
                chk("frame_done", bus.frame_done, e.fd);
                chk("busy", bus.busy, e.b);
            end
        end
    end

    function automatic void push(bit v, logic [3:0] s, bit b);
        exp_q.push_back({v, s, fd_p, b});
        fd_p = 1'b0;
    endfunction

    // Reference: frames walk the unmasked index list; a stop ends the segment it lands in.
    task automatic build(input bit md, input int d, input logic [15:0] m,
                         input int stop_c, input bit with_stop, output int n);
        int lst[$];
        int dl, c, seg0, n0;
        bit done;
        n0 = exp_q.size();
        for (int i = 0; i < 16; i++) if (!m[i]) lst.push_back(i);
        dl   = (d == 0) ? 1 : d;
        c    = 0;
        done = with_stop || (lst.size() == 0);
        while (!done) begin
            for (int k = 0; k < lst.size(); k++) begin
                seg0    = c;
                cur_sel = 4'(lst[k]);
                repeat (dl) begin push(1'b1, cur_sel, 1'b1); c++; end
                if (k == lst.size() - 1) fd_p = 1'b1;
                if ((stop_c >= seg0 && stop_c < c) || (md && k == lst.size() - 1)) begin
                    done = 1'b1;
                    break;
                end
                if (BLK > 0) begin
                    seg0 = c;
                    repeat (BLK) begin push(1'b0, cur_sel, 1'b1); c++; end
                    if (stop_c >= seg0 && stop_c < c) begin done = 1'b1; break; end
                end
            end
        end
        repeat (3) push(1'b0, cur_sel, 1'b0);
        n = exp_q.size() - n0;
    endtask

    task automatic run(input bit md, input int d, input logic [15:0] m,
                       input int stop_c, input bit with_stop);
        int n, t;
        @(negedge clk);
        bus.mode      = md;
        bus.dwell     = DW'(d);
        bus.skip_mask = m;
        bus.start     = 1'b1;
        bus.stop      = with_stop;
        build(md, d, m, stop_c, with_stop, n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.stop  = (c == stop_c);
        end
        bus.stop = 1'b0;
        t = 0;
        while (exp_q.size() > 0 && t < 5) begin @(negedge clk); t++; end
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        bit   md;
        int   d, sc;
        logic [15:0] m;
        bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0;
        bus.dwell = '0;   bus.skip_mask = '0;
        repeat (2) @(negedge clk);
        chk("rst_sel", bus.sel, 0);
        chk("rst_valid", bus.sel_valid, 0);
        chk("rst_fd", bus.frame_done, 0);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b1;

        // Reset in the middle of a dwell.
        @(negedge clk);
        bus.dwell = 8'd5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mid_valid", bus.sel_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.sel_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_fd", bus.frame_done, 0);
        chk("mid_rst_sel", bus.sel, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cur_sel = 4'd0;
        repeat (2) @(negedge clk);
        run(1'b1, 1, 16'h0000, -1, 1'b0);

        run(1'b1, 3, 16'h0000, -1, 1'b0);
        run(1'b0, 0, 16'hFFF0, 21, 1'b0);
        run(1'b0, 4, 16'h0000, 5 * (4 + BLK) + 1, 1'b0);
        run(1'b0, 2, 16'hFFFF, -1, 1'b0);
        run(1'b0, 2, 16'h0000, -1, 1'b1);
        run(1'b0, 2, 16'hFFFC, 13, 1'b0);
        run(1'b0, 3, 16'hFFBF, 17, 1'b0);

        for (int r = 0; r < 10; r++) begin
            md = $urandom_range(0, 1);
            d  = $urandom_range(0, 4);
            m  = 16'($urandom) & 16'($urandom);
            sc = md ? $urandom_range(0, 150) : $urandom_range(0, 60);
            run(md, d, m, sc, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
